// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode and a start/busy/done handshake.
// Operands are extended by one bit so that a single two's-complement datapath handles both modes.
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int W1 = WIDTH + 1;
  localparam int AW = W1 + 1;
  localparam int CW = $clog2(W1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [W1-1:0]        q_q, q_d;
  logic                 q1_q, q1_d;
  logic [W1-1:0]        m_q, m_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [W1-1:0]        ext_mr, ext_mc;
  logic [AW-1:0]        m_wide;
  logic [AW-1:0]        addsub;
  logic [AW-1:0]        a_sh;
  logic [W1-1:0]        q_sh;
  logic                 q1_sh;

  assign ext_mr = {signed_mode & multiplier[WIDTH-1], multiplier};
  assign ext_mc = {signed_mode & multiplicand[WIDTH-1], multiplicand};
  assign m_wide = {m_q[W1-1], m_q};

  always_comb begin
    addsub = a_q;
    case ({q_q[0], q1_q})
      2'b01:   addsub = a_q + m_wide;
      2'b10:   addsub = a_q - m_wide;
      default: addsub = a_q;
    endcase
  end

  // One iteration: add/subtract, then arithmetic right shift of {A,Q,Q-1}.
  assign {a_sh, q_sh, q1_sh} = {addsub[AW-1], addsub, q_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = ext_mc;
          q_d     = ext_mr;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_sh;
        q_d     = q_sh;
        q1_d    = q1_sh;
        count_d = count_q + CW'(1);
        if (count_q == CW'(W1 - 1)) begin
          product_d = {a_sh[WIDTH-2:0], q_sh};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: WIDTH=16 and WIDTH=8 instances, vector tables,
// random operands against an arithmetic reference, and handshake/reset corner sequences.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] mr16 = '0, md16 = '0;
  logic        busy16, done16;
  logic [31:0] product16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  mr8 = '0, md8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplier(mr16), .multiplicand(md16),
    .busy(busy16), .done(done16), .product(product16)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplier(mr8), .multiplicand(md8),
    .busy(busy8), .done(done8), .product(product8)
  );

  typedef struct {
    bit          sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec16_t;

  typedef struct {
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec8_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret operands as integers in the chosen mode and multiply.
  function automatic logic [63:0] ref_mul(int w, bit sm, logic [31:0] a, logic [31:0] b);
    longint x, y;
    logic [63:0] r, mask;
    x = longint'(a);
    y = longint'(b);
    if (sm && a[w-1]) x = x - (longint'(1) << w);
    if (sm && b[w-1]) y = y - (longint'(1) << w);
    r = 64'(x * y);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return r & mask;
  endfunction

  // Launches one operation, scrambles inputs after the latching edge, and
  // reports product, start-to-done latency (edges incl. sampling edge), busy cycles, done count.
  task automatic op16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] p, output int lat, output int bc, output int dc);
    int k;
    @(negedge clk);
    sm16 = sm; mr16 = a; md16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    k = 0; lat = -1; bc = 0; dc = 0; p = '0;
    while (k < 60) begin
      if (k == 2) begin
        mr16 = 16'($urandom); md16 = 16'($urandom); sm16 = 1'($urandom);
      end
      if (busy16) bc++;
      if (done16) begin
        dc++;
        if (lat < 0) begin
          lat = k + 1;
          p = product16;
        end
      end
      if (!busy16) break;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat, output int dc);
    int k;
    @(negedge clk);
    sm8 = sm; mr8 = a; md8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0; lat = -1; dc = 0; p = '0;
    while (k < 40) begin
      if (k == 2) begin
        mr8 = 8'($urandom); md8 = 8'($urandom); sm8 = 1'($urandom);
      end
      if (done8) begin
        dc++;
        if (lat < 0) begin
          lat = k + 1;
          p = product8;
        end
      end
      if (!busy8) break;
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    vec16_t      tbl16[9];
    vec8_t       tbl8[4];
    logic [31:0] p32;
    logic [15:0] p16;
    logic [31:0] dp[2];
    int          dk[2];
    int          lat, bc, dc, k, n;
    bit          sm;
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;

    tbl16[0] = '{1'b1, 16'd3,    16'd4,    32'h0000000C};
    tbl16[1] = '{1'b1, 16'hFFD6, 16'hFFEB, 32'h00000372};
    tbl16[2] = '{1'b1, 16'd9,    16'hFFF4, 32'hFFFFFF94};
    tbl16[3] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    tbl16[4] = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
    tbl16[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl16[6] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    tbl16[7] = '{1'b1, 16'h0000, 16'h1234, 32'h00000000};
    tbl16[8] = '{1'b0, 16'h8000, 16'h0002, 32'h00010000};

    tbl8[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl8[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl8[2] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81};
    tbl8[3] = '{1'b0, 8'h00, 8'hFF, 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_done16", 64'(done16), 64'd0);
    chk("rst_prod16", 64'(product16), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_prod8", 64'(product8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, WIDTH=16
    for (int i = 0; i < 9; i++) begin
      op16(tbl16[i].sm, tbl16[i].a, tbl16[i].b, p32, lat, bc, dc);
      $display("vec16[%0d] sm=%0d %h*%h -> %h lat=%0d busy=%0d", i, tbl16[i].sm,
               tbl16[i].a, tbl16[i].b, p32, lat, bc);
      chk($sformatf("vec16_%0d_prod", i), 64'(p32), 64'(tbl16[i].exp));
      chk($sformatf("vec16_%0d_lat", i), 64'(lat), 64'd18);
      chk($sformatf("vec16_%0d_busy", i), 64'(bc), 64'd18);
      chk($sformatf("vec16_%0d_dcnt", i), 64'(dc), 64'd1);
    end

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      sm = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) ra = sm ? 16'h8000 : 16'hFFFF;
      op16(sm, ra, rb, p32, lat, bc, dc);
      $display("rnd16[%0d] sm=%0d %h*%h -> %h", i, sm, ra, rb, p32);
      chk($sformatf("rnd16_%0d_prod", i), 64'(p32), ref_mul(16, sm, 32'(ra), 32'(rb)));
      chk($sformatf("rnd16_%0d_lat", i), 64'(lat), 64'd18);
    end

    // Start while busy with changed operands is ignored
    @(negedge clk);
    sm16 = 1'b1; mr16 = 16'd5; md16 = 16'd7; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    k = 0; dc = 0; p32 = '0;
    while (k < 40) begin
      if (k == 3) begin
        mr16 = 16'd100; md16 = 16'd100; start16 = 1'b1;
      end
      if (k == 5) start16 = 1'b0;
      if (done16) begin
        dc++;
        p32 = product16;
      end
      @(posedge clk); #1;
      k++;
    end
    $display("busy_start: product=%h dones=%0d", p32, dc);
    chk("busy_start_prod", 64'(p32), 64'h23);
    chk("busy_start_dcnt", 64'(dc), 64'd1);
    chk("busy_start_idle", 64'(busy16), 64'd0);
    chk("busy_start_hold", 64'(product16), 64'h23);

    // Reset mid-operation
    @(negedge clk);
    sm16 = 1'b1; mr16 = 16'd9; md16 = 16'd9; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("mid_reset: busy=%0d done=%0d product=%h", busy16, done16, product16);
    chk("midrst_busy", 64'(busy16), 64'd0);
    chk("midrst_done", 64'(done16), 64'd0);
    chk("midrst_prod", 64'(product16), 64'd0);
    dc = 0;
    for (int i = 0; i < 25; i++) begin
      if (done16 || busy16) dc++;
      @(posedge clk); #1;
    end
    chk("midrst_quiet", 64'(dc), 64'd0);
    op16(1'b1, 16'd2, 16'd3, p32, lat, bc, dc);
    $display("after_reset: 2*3 -> %h", p32);
    chk("midrst_after", 64'(p32), 64'd6);

    // Back-to-back with start held high
    @(negedge clk);
    sm16 = 1'b1; mr16 = 16'd6; md16 = 16'd7; start16 = 1'b1;
    @(posedge clk); #1;
    mr16 = 16'hFFFA; md16 = 16'd7;
    k = 0; n = 0;
    dk[0] = -1; dk[1] = -1; dp[0] = '0; dp[1] = '0;
    while (k < 80 && n < 2) begin
      if (done16) begin
        dk[n] = k;
        dp[n] = product16;
        n++;
        if (n == 2) start16 = 1'b0;
      end
      if (n < 2) begin
        @(posedge clk); #1;
        k++;
      end
    end
    start16 = 1'b0;
    $display("b2b: done@%0d prod=%h, done@%0d prod=%h", dk[0], dp[0], dk[1], dp[1]);
    chk("b2b_prod0", 64'(dp[0]), 64'd42);
    chk("b2b_prod1", 64'(dp[1]), 64'hFFFFFFD6);
    chk("b2b_first_done", 64'(dk[0]), 64'd17);
    chk("b2b_spacing", 64'(dk[1] - dk[0]), 64'd19);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_idle", 64'(busy16), 64'd0);

    // WIDTH=8 instance
    for (int i = 0; i < 4; i++) begin
      op8(tbl8[i].sm, tbl8[i].a, tbl8[i].b, p16, lat, dc);
      $display("vec8[%0d] sm=%0d %h*%h -> %h lat=%0d", i, tbl8[i].sm, tbl8[i].a, tbl8[i].b, p16, lat);
      chk($sformatf("vec8_%0d_prod", i), 64'(p16), 64'(tbl8[i].exp));
      chk($sformatf("vec8_%0d_lat", i), 64'(lat), 64'd10);
      chk($sformatf("vec8_%0d_dcnt", i), 64'(dc), 64'd1);
    end
    for (int i = 0; i < 20; i++) begin
      sm = 1'($urandom);
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      op8(sm, ra8, rb8, p16, lat, dc);
      $display("rnd8[%0d] sm=%0d %h*%h -> %h", i, sm, ra8, rb8, p16);
      chk($sformatf("rnd8_%0d_prod", i), 64'(p16), ref_mul(8, sm, 32'(ra8), 32'(rb8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
